// File: rtl/key_press_driver.sv
// Turns one-cycle press requests into key waveforms (HOLD_CYCLES high, GAP_CYCLES low),
// queueing up to MAX_PENDING requests. Define PRESS_OVERFLOW_EN for always-ready mode with a sticky drop flag.
module key_press_driver #(
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 1,
  parameter int MAX_PENDING = 7,
  parameter int PEND_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              req,
  output logic              ready,
  output logic              press,
  output logic              busy,
  output logic              done,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] MAX_P     = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0] ONE_P     = PEND_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [PEND_W-1:0]  r_pending;
  logic               r_press;
  logic               r_done;
  logic               r_overflow;

  logic               w_start;
  logic               w_accept;
  logic               w_drop;
  logic               w_has_pending;

  assign w_has_pending = (r_pending != {PEND_W{1'b0}});

  // A queued request is consumed when a new press begins (from IDLE or at the end of GAP).
  always_comb begin
    w_start = 1'b0;
    case (r_state)
      S_IDLE:  w_start = w_has_pending;
      S_GAP:   w_start = (r_gap_cnt == {GAP_W{1'b0}}) && w_has_pending;
      default: w_start = 1'b0;
    endcase
  end

`ifdef PRESS_OVERFLOW_EN
  // Always ready; at full a request survives only if a consume frees a slot this cycle.
  assign ready    = 1'b1;
  assign w_accept = req & ((r_pending != MAX_P) | w_start);
  assign w_drop   = req & (r_pending == MAX_P) & ~w_start;
`else
  assign ready    = (r_pending < MAX_P);
  assign w_accept = req & ready;
  assign w_drop   = 1'b0;
`endif

  assign press    = r_press;
  assign done     = r_done;
  assign pending  = r_pending;
  assign overflow = r_overflow;
  assign busy     = (r_state != S_IDLE) || w_has_pending;

  // Press sequencer: queue bookkeeping, state, counters and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= {HOLD_W{1'b0}};
      r_gap_cnt  <= {GAP_W{1'b0}};
      r_pending  <= {PEND_W{1'b0}};
      r_press    <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;

      case ({w_accept, w_start})
        2'b10:   r_pending <= r_pending + ONE_P;
        2'b01:   r_pending <= r_pending - ONE_P;
        default: r_pending <= r_pending;
      endcase

      if (w_drop) begin
        r_overflow <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_HOLD;
            r_press    <= 1'b1;
            r_hold_cnt <= HOLD_LAST;
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == {HOLD_W{1'b0}}) begin
            r_state   <= S_GAP;
            r_press   <= 1'b0;
            r_done    <= 1'b1;
            r_gap_cnt <= GAP_LAST;
          end else begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          end
        end
        S_GAP: begin
          if (r_gap_cnt != {GAP_W{1'b0}}) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end else if (w_start) begin
            r_state    <= S_HOLD;
            r_press    <= 1'b1;
            r_hold_cnt <= HOLD_LAST;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_press <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_press_driver.sv
// Directed self-checking bench for key_press_driver (HOLD=3, GAP=1, MAX_PENDING=7).
// Expectations follow PRESS_OVERFLOW_EN when it is defined for the build.
module tb_key_press_driver;

`ifdef PRESS_OVERFLOW_EN
  localparam int OVF = 1;
`else
  localparam int OVF = 0;
`endif

  logic       Clock;
  logic       Reset;
  logic       req;
  logic       ready;
  logic       press;
  logic       busy;
  logic       done;
  logic [2:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  int   n_rise     = 0;
  int   n_done     = 0;
  logic prev_press = 1'b0;
  int   snap_rise;
  int   snap_done;

  int exp_p1    [5]  = '{0, 1, 1, 1, 0};
  int exp_d1    [5]  = '{0, 0, 0, 0, 1};
  int exp_press2[14] = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 0};
  int exp_pend2 [14] = '{1, 1, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0};
  int exp_done2 [14] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
  int exp_pend3 [10] = '{1, 1, 2, 3, 4, 4, 5, 6, 7, ((OVF != 0) ? 7 : 6)};
  int exp_pend5 [12] = '{1, 1, 2, 3, 4, 4, 5, 6, 7, ((OVF != 0) ? 7 : 6), 7, 7};
  int exp_ovf5  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OVF, OVF};

  key_press_driver #(
    .HOLD_CYCLES(3),
    .GAP_CYCLES (1),
    .MAX_PENDING(7)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .req     (req),
    .ready   (ready),
    .press   (press),
    .busy    (busy),
    .done    (done),
    .pending (pending),
    .overflow(overflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Downstream keypress edge detector and done-pulse counter.
  always @(posedge Clock) begin
    prev_press <= press;
    if (press === 1'b1 && prev_press === 1'b0) n_rise <= n_rise + 1;
    if (done === 1'b1) n_done <= n_done + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (3) step();
    Reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && busy !== 1'b0; i++) step();
    check_eq(tag, 32'(busy), 32'd0);
    repeat (2) step();
  endtask

  initial begin
    Reset = 1'b1;
    req   = 1'b0;
    do_reset();

    // Test 1: reset state, single press
    check_eq("rst_press",    32'(press),    32'd0);
    check_eq("rst_done",     32'(done),     32'd0);
    check_eq("rst_pending",  32'(pending),  32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_busy",     32'(busy),     32'd0);
    check_eq("rst_ready",    32'(ready),    32'd1);
    req = 1'b1;
    step();
    req = 1'b0;
    check_eq("t1_pending_after_accept", 32'(pending), 32'd1);
    check_eq("t1_press_after_accept",   32'(press),   32'd0);
    for (int i = 1; i < 5; i++) begin
      step();
      check_eq("t1_press", 32'(press), 32'(exp_p1[i]));
      check_eq("t1_done",  32'(done),  32'(exp_d1[i]));
      check_eq("t1_busy",  32'(busy),  32'd1);
    end
    step();
    check_eq("t1_busy_end", 32'(busy), 32'd0);
    check_eq("t1_done_end", 32'(done), 32'd0);

    // Test 2: three back-to-back requests
    snap_rise = n_rise;
    snap_done = n_done;
    req = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (i == 2) req = 1'b0;
      check_eq("t2_press",   32'(press),   32'(exp_press2[i]));
      check_eq("t2_pending", 32'(pending), 32'(exp_pend2[i]));
      check_eq("t2_done",    32'(done),    32'(exp_done2[i]));
    end
    check_eq("t2_rises", 32'(n_rise - snap_rise), 32'd3);
    check_eq("t2_dones", 32'(n_done - snap_done), 32'd3);

    // Test 4: reset on the second HOLD cycle with two pending
    req = 1'b1;
    repeat (3) step();
    req = 1'b0;
    check_eq("t4_pre_pending", 32'(pending), 32'd2);
    check_eq("t4_pre_press",   32'(press),   32'd1);
    snap_done = n_done;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_eq("t4_press",   32'(press),   32'd0);
    check_eq("t4_pending", 32'(pending), 32'd0);
    check_eq("t4_busy",    32'(busy),    32'd0);
    check_eq("t4_done",    32'(done),    32'd0);
    step();
    check_eq("t4_done_after", 32'(done), 32'd0);
    check_eq("t4_no_done_pulse", 32'(n_done - snap_done), 32'd0);
    req = 1'b1;
    step();
    req = 1'b0;
    for (int i = 1; i < 5; i++) begin
      step();
      check_eq("t4_press_again", 32'(press), 32'(exp_p1[i]));
    end

    // Test 6: request lands on the last GAP cycle with nothing pending
    check_eq("t6_in_gap", 32'(busy), 32'd1);
    req = 1'b1;
    step();
    req = 1'b0;
    check_eq("t6_press_low",  32'(press),   32'd0);
    check_eq("t6_pending",    32'(pending), 32'd1);
    check_eq("t6_busy",       32'(busy),    32'd1);
    step();
    check_eq("t6_press_high", 32'(press),   32'd1);
    check_eq("t6_pending0",   32'(pending), 32'd0);
    drain("t6_drain");

    // Test 3: req held high for 10 cycles from idle
    snap_rise = n_rise;
    req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("t3_pending", 32'(pending), 32'(exp_pend3[i]));
      check_eq("t3_ready",   32'(ready),
               (OVF != 0) ? 32'd1 : ((exp_pend3[i] < 7) ? 32'd1 : 32'd0));
    end
    req = 1'b0;
    drain("t3_drain");
    check_eq("t3_presses", 32'(n_rise - snap_rise), (OVF != 0) ? 32'd10 : 32'd9);

    // Test 5: request while full and not consuming
    do_reset();
    snap_rise = n_rise;
    req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check_eq("t5_pending",  32'(pending),  32'(exp_pend5[i]));
      check_eq("t5_overflow", 32'(overflow), 32'(exp_ovf5[i]));
    end
    req = 1'b0;
    drain("t5_drain");
    check_eq("t5_presses",        32'(n_rise - snap_rise), 32'd10);
    check_eq("t5_overflow_drain", 32'(overflow), 32'(OVF));
    do_reset();
    check_eq("t5_overflow_reset", 32'(overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
